// File: rtl/fc_feature_packer.sv
// Serial-to-parallel packer for the FC layer input vector.
// A fill buffer collects one frame while the previously completed frame is held on vec_data.
module fc_feature_packer #(
  parameter int DATA_BITS   = 32,
  parameter int NUM_IN      = 128,
  parameter int HOLD_CYCLES = 12,
  parameter int GAP_CYCLES  = 0,
  parameter int CNT_BITS    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_BITS-1:0]        s_data,
  input  logic                        s_valid,
  input  logic                        s_last,
  output logic                        s_ready,
  output logic [NUM_IN*DATA_BITS-1:0] vec_data,
  output logic                        vec_valid,
  output logic                        frame_err,
  output logic [CNT_BITS-1:0]         frame_count
);

  localparam int IDX_W    = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int HOLD_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IN - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PRESENT, ST_GAP} state_t;

  state_t              state_reg, state_next;
  logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;
  logic [GAP_W-1:0]    gap_cnt_reg, gap_cnt_next;
  logic                vec_valid_reg, vec_valid_next;
  logic [CNT_BITS-1:0] frame_count_reg, frame_count_next;
  logic                load;

  logic [IDX_W-1:0]    wr_idx_reg;
  logic                full_reg;
  logic                frame_err_reg;
  logic                accept;

  assign s_ready     = !full_reg && !rst;
  assign accept      = s_valid && s_ready;
  assign vec_valid   = vec_valid_reg;
  assign frame_err   = frame_err_reg;
  assign frame_count = frame_count_reg;

  // Fill-side bookkeeping; a short frame (early s_last) is discarded by rewinding wr_idx.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx_reg    <= '0;
      full_reg      <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      frame_err_reg <= 1'b0;
      if (load) begin
        full_reg <= 1'b0;
      end
      if (accept) begin
        if (wr_idx_reg == LAST_IDX) begin
          full_reg      <= 1'b1;
          wr_idx_reg    <= '0;
          frame_err_reg <= !s_last;
        end else if (s_last) begin
          wr_idx_reg    <= '0;
          frame_err_reg <= 1'b1;
        end else begin
          wr_idx_reg <= wr_idx_reg + IDX_W'(1);
        end
      end
    end
  end

  // Per-element fill slot and output slot; the output slot only changes on a load.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_elem
      logic [DATA_BITS-1:0] fill_reg;
      logic [DATA_BITS-1:0] out_reg;

      always_ff @(posedge clk) begin
        if (accept && (wr_idx_reg == IDX_W'(gi))) begin
          fill_reg <= s_data;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          out_reg <= '0;
        end else if (load) begin
          out_reg <= fill_reg;
        end
      end

      assign vec_data[gi*DATA_BITS +: DATA_BITS] = out_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      hold_cnt_reg    <= '0;
      gap_cnt_reg     <= '0;
      vec_valid_reg   <= 1'b0;
      frame_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      hold_cnt_reg    <= hold_cnt_next;
      gap_cnt_reg     <= gap_cnt_next;
      vec_valid_reg   <= vec_valid_next;
      frame_count_reg <= frame_count_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    hold_cnt_next    = hold_cnt_reg;
    gap_cnt_next     = gap_cnt_reg;
    vec_valid_next   = vec_valid_reg;
    frame_count_next = frame_count_reg;
    load             = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (full_reg) begin
          load             = 1'b1;
          vec_valid_next   = 1'b1;
          hold_cnt_next    = HOLD_W'(HOLD_CYCLES - 1);
          frame_count_next = frame_count_reg + CNT_BITS'(1);
          state_next       = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (hold_cnt_reg == '0) begin
          vec_valid_next = 1'b0;
          if (GAP_CYCLES > 0) begin
            state_next   = ST_GAP;
            gap_cnt_next = GAP_W'(GAP_LOAD);
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          hold_cnt_next = hold_cnt_reg - HOLD_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_reg == '0) begin
          state_next = ST_IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg - GAP_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule
